// File: rtl/mac_window_accum_pkg.sv
// Shared parameters for the multiply-add result path.
//   P         : operand width of the multiply-add stage (its results are 2P bits)
//   N         : default window length in samples (power of two, >= 2)
//   state_e   : window accumulator states
//   acc_width : accumulator width that cannot overflow for a given P and N
package mac_window_accum_pkg;

    localparam int P = 8;
    localparam int N = 8;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_STALL = 1'b1
    } state_e;

    // A full window of N 2P-bit samples needs log2(N) extra bits.
    function automatic int acc_width(input int p, input int n);
        return 2 * p + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_window_accum.sv
// Sums fixed windows of N samples from the multiply-add stage and presents
// the window sum and truncated mean through a one-entry valid/ready buffer.
// Upstream is stalled only when a window would complete while the buffer
// still holds an unconsumed result.
//
// Ports:
//   C          in   clock, posedge
//   RST_N      in   asynchronous active-low reset
//   DATA_IN    in   2P-bit sample
//   IN_VALID   in   DATA_IN valid
//   IN_READY   out  sample accepted this cycle when IN_VALID is high
//   CLR        in   synchronous clear of the partial window
//   SUM_OUT    out  completed window sum
//   MEAN_OUT   out  completed window mean (SUM_OUT >> log2(N))
//   OUT_VALID  out  buffer holds an unconsumed result
//   OUT_READY  in   consumer takes the result
//   CNT        out  samples accepted in the current partial window
//
// state   | meaning
// S_FILL  | accumulating samples of the current window
// S_STALL | window needs its last sample but the output buffer is still full
module mac_window_accum
    import mac_window_accum_pkg::*;
#(
    parameter int N = mac_window_accum_pkg::N
) (
    input  logic                              C,
    input  logic                              RST_N,
    input  logic [2*P-1:0]                    DATA_IN,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    input  logic                              CLR,
    output logic [acc_width(P, N)-1:0]        SUM_OUT,
    output logic [2*P-1:0]                    MEAN_OUT,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [$clog2(N)-1:0]              CNT
);

    localparam int L     = $clog2(N);
    localparam int ACC_W = acc_width(P, N);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [2*P-1:0]     mean_q, mean_d;
    logic [L-1:0]       cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;

    logic               last_slot;
    logic               in_ready;
    logic               accept;
    logic [ACC_W-1:0]   win_sum;

    assign last_slot = (cnt_q == L'(N - 1));
    assign win_sum   = acc_q + ACC_W'(DATA_IN);
    assign accept    = IN_VALID && in_ready;

    // State register
    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_FILL;
            acc_q       <= '0;
            sum_q       <= '0;
            mean_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            mean_q      <= mean_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (CLR) begin
            state_d = S_FILL;
        end else begin
            unique case (state_q)
                S_FILL:  if (last_slot && out_valid_q) state_d = S_STALL;
                S_STALL: if (!out_valid_q)             state_d = S_FILL;
                default:                               state_d = S_FILL;
            endcase
        end
    end

    // Output / datapath logic. IN_READY depends only on registered state and
    // CLR, so OUT_READY never reaches it combinationally; the price is one
    // bubble when the last sample meets a consume in the same cycle.
    always_comb begin
        in_ready    = !CLR && !(out_valid_q && last_slot);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mean_d      = mean_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end

        if (CLR) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last_slot) begin
                // in_ready guarantees the buffer is empty here
                sum_d       = win_sum;
                mean_d      = win_sum[ACC_W-1:L];
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = win_sum;
                cnt_d = cnt_q + L'(1);
            end
        end
    end

    assign IN_READY  = in_ready;
    assign SUM_OUT   = sum_q;
    assign MEAN_OUT  = mean_q;
    assign OUT_VALID = out_valid_q;
    assign CNT       = cnt_q;

endmodule

// File: doc/mac_window_accum.md
Name: mac_window_accum

Overview:
- Downstream consumer of the multiply-add stage: takes its registered 2P-bit result stream (A1*B1+C1), sums fixed windows of N samples, and emits window sum and window mean.
- Output uses a one-entry buffer with a valid/ready handshake.
- Applies backpressure upstream only when a completed window cannot be stored.
- Sits between the multiply-add stage and the result collector/readout logic.

Parameters:
- P, 8 (from shared package), operand width of the upstream stage; input width is 2P.
- N, 8, window length in samples. Must be a power of 2, at least 2.
- L, $clog2(N) (localparam), mean shift and counter width.
- ACC_W, 2P+L (localparam), accumulator/sum width. Guarantees no overflow.

Ports:
- C  in  1  clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- DATA_IN  in  2P  sample from the multiply-add stage.
- IN_VALID  in  1  DATA_IN valid this cycle.
- IN_READY  out  1  block accepts DATA_IN this cycle.
- CLR  in  1  synchronous clear of the partial window.
- SUM_OUT  out  ACC_W  completed window sum.
- MEAN_OUT  out  2P  completed window mean, SUM_OUT >> L (truncating).
- OUT_VALID  out  1  SUM_OUT/MEAN_OUT hold an unconsumed result.
- OUT_READY  in  1  consumer takes the result.
- CNT  out  L  samples accepted in the current partial window.

Behaviour:
- Reset: async on RST_N low. Clears acc, CNT, SUM_OUT, MEAN_OUT, OUT_VALID; state goes to S_FILL. IN_READY is 1 after reset release.
- Accept condition: IN_VALID && IN_READY at posedge C. No accept means no state change apart from the output handshake.
- States:
  - S_FILL: accumulating.
  - S_STALL: window complete-pending; the Nth sample is not accepted because the output buffer is full.
- IN_READY = !CLR && !(OUT_VALID && CNT==N-1). Purely from registered state plus CLR; no combinational path from OUT_READY.
- S_FILL, accept with CNT<N-1: acc <= acc + DATA_IN (zero-extended); CNT <= CNT+1.
- S_FILL, accept with CNT==N-1 (OUT_VALID is necessarily 0):
  - SUM_OUT <= acc+DATA_IN; MEAN_OUT <= (acc+DATA_IN)>>L.
  - OUT_VALID <= 1; acc <= 0; CNT <= 0.
  - Latency: result visible the cycle after the Nth accept.
- S_FILL to S_STALL: when CNT==N-1 and OUT_VALID==1. Returns to S_FILL the cycle after OUT_VALID falls.
- Output handshake: OUT_VALID && OUT_READY clears OUT_VALID next cycle. SUM_OUT/MEAN_OUT hold their values until reloaded.
- Simultaneous consume and Nth sample: not accepted in that cycle, because IN_READY was low. Accepted the following cycle. Costs one bubble per back-to-back window; this is intended.
- CLR: acc <= 0, CNT <= 0, state S_FILL. Does not touch the output buffer or OUT_VALID. Takes priority over accept; IN_READY is low while CLR is high, so no sample is lost silently.
- Reset mid-window or with OUT_VALID high discards all data. No partial result is emitted.
- Data outputs are stable while OUT_VALID=1 && OUT_READY=0.

Decomposition:
- Shared parameter package (same package that provides P): add window-length constant N, the state enum (S_FILL, S_STALL), and ACC_W derivation.
- Single module; no sub-module needed.
- Optional: the output buffer may be a small internal always block rather than a separate module.

Test Plan (P=8, N=4):
- Reset then 4 accepts 100,200,300,400 with OUT_READY=1 -> next cycle OUT_VALID=1, SUM_OUT=1000, MEAN_OUT=250, CNT=0.
- 4 samples of 65025 (255*255+0) -> SUM_OUT=260100, MEAN_OUT=65025; no wrap.
- OUT_READY=0, stream 8 samples of 10 -> first result SUM=40. IN_READY drops with CNT=3. Raise OUT_READY -> OUT_VALID drops, 8th sample accepted the cycle after, second SUM_OUT=40.
- Samples 5,7 then CLR=1 one cycle (IN_VALID held) -> CNT=0, IN_READY=0 during CLR. Next 4 samples of 1 give SUM_OUT=4.
- Samples 9,9,9 then RST_N low mid-cycle -> immediately OUT_VALID=0, CNT=0, SUM_OUT=0. After release, 4 samples of 2 give SUM_OUT=8.
- Non-divisible mean: samples 1,1,1,2 -> SUM_OUT=5, MEAN_OUT=1 (truncated).
